// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, PPROT bit positions and
// the address-alignment helper used by requester, completer and bench.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    localparam logic [2:0] PROT_PRIV  = 3'b001;
    localparam logic [2:0] PROT_NSEC  = 3'b010;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    // nbytes is a power of two (1, 2 or 4)
    function automatic logic is_aligned(
        input logic [31:0] addr,
        input int unsigned nbytes
    );
        return (addr & 32'(nbytes - 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: saturating, cleared on SETUP entry,
// expired pulses on the wait cycle that brings the count to the limit.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic prst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (prst || clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && en && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one transfer at a time from a valid/ready command
// stream, result returned on a valid/ready response stream.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_STRB      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_STRB-1:0]  cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            prot,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_STRB-1:0]  pstrb,
    input  logic                  pready,
    input  logic                  slverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    apb_state_t state, state_n;

    logic aligned;
    logic accept;
    logic wait_clr;
    logic wait_en;
    logic expired;

    logic [DATA_STRB-1:0] strb_q;

    assign aligned = is_aligned(32'(cmd_addr), DATA_STRB);
    assign accept  = (state == IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (prst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        wait_clr = 1'b0;
        wait_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n  = aligned ? SETUP : RESP;
                    wait_clr = aligned;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_n = RESP;
                end else begin
                    wait_en = 1'b1;
                    if (expired) state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .prst   (prst),
        .clr    (wait_clr),
        .en     (wait_en),
        .expired(expired)
    );

    // Request fields are latched once and held for the whole transfer
    always_ff @(posedge clk) begin
        if (prst) begin
            paddr       <= '0;
            pwdata      <= '0;
            strb_q      <= '0;
            prot        <= '0;
            pwrite      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                paddr       <= cmd_addr;
                pwdata      <= cmd_wdata;
                strb_q      <= cmd_strb;
                prot        <= cmd_prot;
                pwrite      <= cmd_write;
                rsp_rdata   <= '0;
                rsp_err     <= !aligned;
                rsp_timeout <= 1'b0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata <= (pwrite || slverr) ? '0 : prdata;
                    rsp_err   <= slverr;
                end else if (expired) begin
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign pstrb     = pwrite ? strb_q : '0;

endmodule
